// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_stage_skid: 2-entry skid pipeline register with flush, stall modes  |
// | and a saturating stall-cycle counter.          Revision: 1.0             |
// +--------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int CTRL_W     = 2,
  parameter int DATA_W     = 37,
  parameter int STALL_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit               c_bubble  = (STALL_MODE != 0);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic              r_h_valid, r_s_valid, r_in_ready;
  logic [CTRL_W-1:0] r_h_ctrl, r_s_ctrl;
  logic [DATA_W-1:0] r_h_data, r_s_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_eff_ready, w_accept, w_emit, w_cnt_inc, w_out_valid;

  assign w_eff_ready = out_ready & ~stall;
  assign w_accept    = in_valid & r_in_ready & ~flush & ~stall;
  assign w_emit      = r_h_valid & w_eff_ready & ~flush;
  assign w_cnt_inc   = r_h_valid & ~w_eff_ready & ~flush & (r_stall_cnt != c_cnt_max);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_h_ctrl   <= '0;
      r_s_ctrl   <= '0;
      r_h_data   <= '0;
      r_s_data   <= '0;
    end else if (flush) begin
      r_h_valid  <= 1'b0;
      r_s_valid  <= 1'b0;
      r_in_ready <= 1'b1;
      r_h_ctrl   <= '0;
      r_s_ctrl   <= '0;
    end else if (w_emit && r_s_valid) begin
      // in_ready is low while S is full, so no accept can coincide here
      r_h_ctrl   <= r_s_ctrl;
      r_h_data   <= r_s_data;
      r_s_valid  <= 1'b0;
      r_s_ctrl   <= '0;
      r_in_ready <= 1'b1;
    end else if (w_accept && (!r_h_valid || w_emit)) begin
      r_h_valid <= 1'b1;
      r_h_ctrl  <= in_ctrl;
      r_h_data  <= in_data;
    end else if (w_accept) begin
      r_s_valid  <= 1'b1;
      r_s_ctrl   <= in_ctrl;
      r_s_data   <= in_data;
      r_in_ready <= 1'b0;
    end else if (w_emit) begin
      r_h_valid <= 1'b0;
      r_h_ctrl  <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_stall_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  // Bubble mode hides the head while stalled; the entry itself is untouched
  assign w_out_valid = r_h_valid & ~(c_bubble & stall);

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_ctrl  = w_out_valid ? r_h_ctrl : '0;
  assign out_data  = r_h_data;
  assign occupancy = {1'b0, r_h_valid} + {1'b0, r_s_valid};
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Bench for pipe_stage_skid: hold-mode (16-bit counter) and bubble-mode (4-bit counter)
// instances driven in lockstep and checked against a queue-based reference.
module tb_pipe_stage_skid;

  logic        CLK, RSTN;
  logic        iv, st, fl, ordy;
  logic [1:0]  ic;
  logic [36:0] id;

  logic        ir0, ov0, ir1, ov1;
  logic [1:0]  oc0, oc1, occ0, occ1;
  logic [36:0] od0, od1;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  pipe_stage_skid #(.CTRL_W(2), .DATA_W(37), .STALL_MODE(0), .CNT_W(16)) dut0 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(iv), .in_ready(ir0), .in_ctrl(ic), .in_data(id),
    .stall(st), .flush(fl), .out_valid(ov0), .out_ready(ordy), .out_ctrl(oc0),
    .out_data(od0), .occupancy(occ0), .stall_cnt(cnt0));

  pipe_stage_skid #(.CTRL_W(2), .DATA_W(37), .STALL_MODE(1), .CNT_W(4)) dut1 (
    .CLK(CLK), .RSTN(RSTN), .in_valid(iv), .in_ready(ir1), .in_ctrl(ic), .in_data(id),
    .stall(st), .flush(fl), .out_valid(ov1), .out_ready(ordy), .out_ctrl(oc1),
    .out_data(od1), .occupancy(occ1), .stall_cnt(cnt1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the stage is a FIFO of at most two entries
  typedef struct packed {logic [1:0] c; logic [36:0] d;} ent_t;
  ent_t        q[$];
  int          m_cnt;
  logic [36:0] m_last;
  bit          m_known;

  task automatic model_reset();
    q.delete();
    m_cnt   = 0;
    m_last  = '0;
    m_known = 1;
  endtask

  task automatic model_step();
    int  sz;
    bit  emit, acc;
    sz = q.size();
    if (fl) begin
      q.delete();
      m_known = 0;
    end else begin
      if (sz > 0 && !(ordy && !st)) m_cnt++;
      emit = (sz > 0) && ordy && !st;
      acc  = iv && (sz < 2) && !st;
      if (emit) void'(q.pop_front());
      if (acc) q.push_back('{c: ic, d: id});
      if (q.size() > 0 && (emit || acc)) begin
        m_last  = q[0].d;
        m_known = 1;
      end
    end
  endtask

  task automatic check_model();
    int          sz;
    logic        e_ov1;
    logic [1:0]  hc;
    logic [63:0] c0, c1;
    sz    = q.size();
    hc    = (sz > 0) ? q[0].c : 2'b00;
    e_ov1 = (sz > 0) && !st;
    c0    = (m_cnt > 65535) ? 64'd65535 : 64'(m_cnt);
    c1    = (m_cnt > 15) ? 64'd15 : 64'(m_cnt);
    chk("m_in_ready0", ir0, sz < 2);
    chk("m_in_ready1", ir1, sz < 2);
    chk("m_out_valid0", ov0, sz > 0);
    chk("m_out_valid1", ov1, e_ov1);
    chk("m_out_ctrl0", oc0, hc);
    chk("m_out_ctrl1", oc1, e_ov1 ? hc : 2'b00);
    chk("m_occ0", occ0, 64'(sz));
    chk("m_occ1", occ1, 64'(sz));
    chk("m_cnt0", cnt0, c0);
    chk("m_cnt1", cnt1, c1);
    if (m_known) begin
      chk("m_data0", od0, m_last);
      chk("m_data1", od1, m_last);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [36:0] d,
                       input logic s, input logic f, input logic r);
    iv = v; ic = c; id = d; st = s; fl = f; ordy = r;
  endtask

  task automatic settle();
    #4;
    check_model();
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  typedef struct {
    logic        iv, st, fl, ordy;
    logic [1:0]  ic;
    logic [36:0] id;
    logic        e_ir, e_ov;
    logic [1:0]  e_oc;
    logic [36:0] e_od;
    logic        chk_d;
    logic [1:0]  e_occ;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    // iv st fl ordy ic id | e_ir e_ov e_oc e_od chk_d e_occ e_cnt  (hold-mode instance)
    tbl[0]  = '{1,0,0,1, 3, 1,  1,0,0, 0, 1,0,0}; // streaming 1,2,3
    tbl[1]  = '{1,0,0,1, 3, 2,  1,1,3, 1, 1,1,0};
    tbl[2]  = '{1,0,0,1, 3, 3,  1,1,3, 2, 1,1,0};
    tbl[3]  = '{0,0,0,1, 0, 0,  1,1,3, 3, 1,1,0};
    tbl[4]  = '{1,0,0,0, 1,10,  1,0,0, 3, 1,0,0}; // backpressure A,B
    tbl[5]  = '{1,0,0,0, 2,11,  1,1,1,10, 1,1,0};
    tbl[6]  = '{1,0,0,0, 3,12,  0,1,1,10, 1,2,1};
    tbl[7]  = '{0,0,0,1, 0, 0,  0,1,1,10, 1,2,2};
    tbl[8]  = '{0,0,0,1, 0, 0,  1,1,2,11, 1,1,2};
    tbl[9]  = '{0,0,0,0, 0, 0,  1,0,0,11, 1,0,2};
    tbl[10] = '{1,0,0,0, 1,20,  1,0,0,11, 1,0,2}; // flush priority
    tbl[11] = '{1,0,0,0, 2,21,  1,1,1,20, 1,1,2};
    tbl[12] = '{1,1,1,1, 3,22,  0,1,1,20, 1,2,3};
    tbl[13] = '{0,0,0,0, 0, 0,  1,0,0, 0, 0,0,3};
    tbl[14] = '{1,0,0,1, 2,30,  1,0,0, 0, 0,0,3};
    tbl[15] = '{0,0,0,1, 0, 0,  1,1,2,30, 1,1,3};

    RSTN = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RSTN = 1'b1;

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].st, tbl[i].fl, tbl[i].ordy);
      settle();
      chk($sformatf("t%0d_in_ready", i), ir0, tbl[i].e_ir);
      chk($sformatf("t%0d_out_valid", i), ov0, tbl[i].e_ov);
      chk($sformatf("t%0d_out_ctrl", i), oc0, tbl[i].e_oc);
      if (tbl[i].chk_d) chk($sformatf("t%0d_out_data", i), od0, tbl[i].e_od);
      chk($sformatf("t%0d_occ", i), occ0, tbl[i].e_occ);
      chk($sformatf("t%0d_cnt", i), cnt0, tbl[i].e_cnt);
      tick();
    end

    // Asynchronous reset with two entries held
    drive(1, 1, 40, 0, 0, 0); settle(); tick();
    drive(1, 2, 41, 0, 0, 0); settle(); tick();
    chk("rst_pre_occ", occ0, 2);
    drive(0, 0, 0, 0, 0, 0);
    RSTN = 1'b0;
    #2;
    chk("rst_in_ready0", ir0, 1);  chk("rst_in_ready1", ir1, 1);
    chk("rst_out_valid0", ov0, 0); chk("rst_out_valid1", ov1, 0);
    chk("rst_out_ctrl0", oc0, 0);  chk("rst_out_data0", od0, 0);
    chk("rst_occ0", occ0, 0);      chk("rst_occ1", occ1, 0);
    chk("rst_cnt0", cnt0, 0);      chk("rst_cnt1", cnt1, 0);
    model_reset();
    @(posedge CLK);
    #1 RSTN = 1'b1;

    // Bubble-mode stall: entry hidden but retained, then emitted
    drive(1, 2, 5, 0, 0, 0); settle(); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1, 0, 1); settle(); tick();
    end
    settle();
    chk("stall_ov1", ov1, 0);
    chk("stall_oc1", oc1, 0);
    chk("stall_od1", od1, 5);
    chk("stall_cnt1", cnt1, 3);
    chk("stall_ov0", ov0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 1); settle();
    chk("unstall_ov1", ov1, 1);
    chk("unstall_oc1", oc1, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0); settle();
    chk("emitted_ov1", ov1, 0);
    tick();

    // Saturation of the 4-bit counter
    RSTN = 1'b0;
    #2 model_reset();
    @(posedge CLK);
    #1 RSTN = 1'b1;
    drive(1, 1, 7, 0, 0, 0); settle(); tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      settle(); tick();
    end
    settle();
    chk("sat_cnt1", cnt1, 4'hF);
    chk("sat_cnt0", cnt0, 20);
    tick();
    settle();
    chk("sat_hold_cnt1", cnt1, 4'hF);
    tick();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), {5'($urandom), 32'($urandom)},
            ($urandom % 5) == 0, ($urandom % 23) == 0, ($urandom % 3) != 0);
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
